multicycle_alu: RTL and testbench

Parametrised, handshaked successor to the single-cycle combinational ALU. It adds a registered result and flags, an iterative shift-add multiply, and iterative logical shifts. It sits between the register-file read stage and writeback. Control issues one operation per `start` pulse and waits for `done`.

---
 rtl/multicycle_alu.sv | 179 +++++++++++++++++
 tb/tb_multicycle_alu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Handshaked ALU between register-file read and writeback. One operation is
//   accepted per start pulse in IDLE; result and flags are registered and
//   announced by a one-cycle done pulse. ADD/SUB/AND/OR/COMPLEMENT finish in
//   one edge, logical shifts iterate one bit per edge, and MUL is an unsigned
//   shift-add iterating one multiplier bit per edge.
//
//   Optional feature: define ALU_MUL_EN to compile in the multiplier datapath.
//   Without it, opcode 5 completes in one edge with result 0 and only Z set.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous active-low reset
//   start            request, sampled only in IDLE
//   operation        opcode: 0 ADD 1 SUB 2 AND 3 OR 4 COMPLEMENT 5 MUL 6 SHL 7 SHR
//   primaryOperand   operand A
//   secondaryOperand operand B (low SAW bits are the shift amount for shifts)
//   result           registered result, held until the next done
//   flags            {overflow, zero, carry, negative}, updated with result
//   busy             operation in progress
//   done             one-cycle pulse when result/flags update
module multicycle_alu #(
  parameter int WIDTH = 16,
  parameter int SAW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] primaryOperand,
  input  logic [WIDTH-1:0] secondaryOperand,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_CPL = 3'd4, OP_MUL = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7
  } op_e;

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  // Counter must hold WIDTH for MUL as well as WIDTH-1 for shifts.
  localparam int CW = SAW + 1;

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;      // operand A; doubles as the shift register
  logic [WIDTH-1:0] b_q;      // operand B; doubles as the multiplier
  logic [CW-1:0]    count;    // iterations remaining before writeback
  logic             shift_c;  // last bit shifted out
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc;    // partial product
  logic [2*WIDTH-1:0] mcand;  // multiplicand, shifted left each iteration
`endif

  logic [WIDTH-1:0] wb_result;
  logic             wb_c;
  logic             wb_v;
  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;

  assign sum_add = {1'b0, a_q} + {1'b0, b_q};
  assign sum_sub = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);

  // Writeback value, evaluated from the latched operands in the final EXEC cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wb_result = '0;
    wb_c      = 1'b0;
    wb_v      = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        wb_result = sum_add[WIDTH-1:0];
        wb_c      = sum_add[WIDTH];
        // Signed overflow: like-signed operands producing the other sign.
        wb_v      = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (wb_result[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        wb_result = sum_sub[WIDTH-1:0];
        wb_c      = sum_sub[WIDTH];
        wb_v      = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (wb_result[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: wb_result = a_q & b_q;
      OP_OR:  wb_result = a_q | b_q;
      OP_CPL: wb_result = ~a_q;
      OP_MUL: begin
`ifdef ALU_MUL_EN
        wb_result = acc[WIDTH-1:0];
        wb_c      = |acc[2*WIDTH-1:WIDTH];
`endif
      end
      OP_SHL, OP_SHR: begin
        wb_result = a_q;
        wb_c      = shift_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: every register is reset, so an aborted operation leaves no residue.
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      count   <= '0;
      shift_c <= 1'b0;
      result  <= '0;
      flags   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef ALU_MUL_EN
      acc     <= '0;
      mcand   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_e'(operation);
            a_q     <= primaryOperand;
            b_q     <= secondaryOperand;
            shift_c <= 1'b0;
            busy    <= 1'b1;
            state   <= S_EXEC;
            unique case (op_e'(operation))
`ifdef ALU_MUL_EN
              OP_MUL:         count <= CW'(WIDTH);
`endif
              OP_SHL, OP_SHR: count <= CW'(secondaryOperand[SAW-1:0]);
              default:        count <= '0;
            endcase
`ifdef ALU_MUL_EN
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, primaryOperand};
`endif
          end
        end
        S_EXEC: begin
          if (count != '0) begin
            count <= count - CW'(1);
            unique case (op_q)
              OP_SHL: begin
                shift_c <= a_q[WIDTH-1];
                a_q     <= a_q << 1;
              end
              OP_SHR: begin
                shift_c <= a_q[0];
                a_q     <= a_q >> 1;
              end
`ifdef ALU_MUL_EN
              OP_MUL: begin
                if (b_q[0]) acc <= acc + mcand;
                mcand <= mcand << 1;
                b_q   <= b_q >> 1;
              end
`endif
              default: ;
            endcase
          end else begin
            result <= wb_result;
            flags  <= {wb_v, (wb_result == '0), wb_c, wb_result[WIDTH-1]};
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  localparam int W = 16;

  logic          clock;
  logic          reset;
  logic          start;
  logic [2:0]    operation;
  logic [W-1:0]  primaryOperand;
  logic [W-1:0]  secondaryOperand;
  logic [W-1:0]  result;
  logic [3:0]    flags;
  logic          busy;
  logic          done;

  int n_vec  = 0;
  int n_miss = 0;

  // Last completed result/flags according to the model, for hold checks.
  logic [W-1:0] last_r = '0;
  logic [3:0]   last_f = '0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .operation        (operation),
    .primaryOperand   (primaryOperand),
    .secondaryOperand (secondaryOperand),
    .result           (result),
    .flags            (flags),
    .busy             (busy),
    .done             (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [3:0] f, output int l);
    logic        c;
    logic        v;
    logic [31:0] w;
    int          sa, sb, s, n;
    c  = 1'b0;
    v  = 1'b0;
    l  = 1;
    r  = '0;
    n  = int'(b[3:0]);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'd0: begin
        w = {16'b0, a} + {16'b0, b};
        r = w[15:0];
        c = w[16];
        s = sa + sb;
        v = (s > 32767) || (s < -32768);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 32767) || (s < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~a;
      3'd5: begin
`ifdef ALU_MUL_EN
        w = {16'b0, a} * {16'b0, b};
        r = w[15:0];
        c = (w[31:16] != 16'h0);
        l = W + 1;
`else
        r = '0;
`endif
      end
      3'd6: begin
        w = {16'b0, a} << n;
        r = w[15:0];
        c = w[16];
        l = n + 1;
      end
      default: begin
        w = {a, 16'b0} >> n;
        r = w[31:16];
        c = w[15];
        l = n + 1;
      end
    endcase
    f = {v, (r == '0), c, r[W-1]};
  endfunction

  // Issue one operation from IDLE (caller is #1 after a rising edge) and
  // check latency, busy, hold behaviour, result, flags and done width.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_r, input logic [3:0] exp_f, input int exp_l,
                        input string name);
    int lat;
    bit seen;
    start = 1'b1; operation = op; primaryOperand = a; secondaryOperand = b;
    @(posedge clock); #1;
    start = 1'b0;
    operation = 3'($urandom); primaryOperand = 16'($urandom); secondaryOperand = 16'($urandom);
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_miss++;
      $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", name, busy, done);
    end
    lat  = 0;
    seen = 0;
    while (!seen && lat < 64) begin
      @(posedge clock); #1;
      lat++;
      if (done === 1'b1) seen = 1;
      else begin
        n_vec++;
        if (busy !== 1'b1 || result !== last_r || flags !== last_f) begin
          n_miss++;
          $display("FAIL %s hold@%0d: busy=%b result=%h flags=%b, required busy=1 result=%h flags=%b",
                   name, lat, busy, result, flags, last_r, last_f);
        end
      end
    end
    n_vec++;
    if (!seen) begin
      n_miss++;
      $display("FAIL %s timeout: no done within %0d edges, required latency %0d", name, lat, exp_l);
      return;
    end
    if (lat != exp_l || result !== exp_r || flags !== exp_f || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL %s: lat=%0d result=%h flags=%b busy=%b, required lat=%0d result=%h flags=%b busy=0",
               name, lat, result, flags, busy, exp_l, exp_r, exp_f);
    end
    last_r = exp_r;
    last_f = exp_f;
    @(posedge clock); #1;
    n_vec++;
    if (done !== 1'b0 || result !== exp_r || flags !== exp_f) begin
      n_miss++;
      $display("FAIL %s done_width: done=%b result=%h flags=%b, required done=0 result=%h flags=%b",
               name, done, result, flags, exp_r, exp_f);
    end
  endtask

  task automatic run_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input string name);
    logic [W-1:0] r;
    logic [3:0]   f;
    int           l;
    model(op, a, b, r, f, l);
    run_op(op, a, b, r, f, l, name);
  endtask

  task automatic test_reset();
    n_vec++;
    if (result !== '0 || flags !== 4'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_miss++;
      $display("FAIL reset: result=%h flags=%b busy=%b done=%b, required all 0", result, flags, busy, done);
    end
  endtask

  task automatic test_directed();
    run_op(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1, "add_overflow");
    run_op(3'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0001, 1, "sub_borrow");
    run_op(3'd6, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 2, "shl_by1");
    run_op(3'd7, 16'h0001, 16'h0000, 16'h0001, 4'b0000, 1, "shr_by0");
`ifdef ALU_MUL_EN
    run_op(3'd5, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 17, "mul_256x256");
    run_op(3'd5, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 17, "mul_3x5");
`else
    run_op(3'd5, 16'h0003, 16'h0005, 16'h0000, 4'b0100, 1, "mul_disabled");
`endif
    run_model(3'd6, 16'hFFFF, 16'h000F, "shl_by15");
    run_model(3'd7, 16'hFFFF, 16'h000F, "shr_by15");
    run_model(3'd1, 16'h1234, 16'h1234, "sub_equal");
    run_model(3'd1, 16'h8000, 16'h0001, "sub_overflow");
    run_model(3'd4, 16'h0F0F, 16'hAAAA, "complement");
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      run_model(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), "random");
    end
  endtask

  // start held high through a MUL: exactly one done, then a new accept at
  // the edge following done.
  task automatic test_back_to_back();
    logic [W-1:0] r1, r2, a2, b2;
    logic [3:0]   f1, f2;
    int           l1, l2, n_done, lat;
    bit           seen;
    a2 = 16'($urandom);
    b2 = 16'($urandom);
    model(3'd5, 16'h00C3, 16'h0101, r1, f1, l1);
    model(3'd0, a2, b2, r2, f2, l2);
    start = 1'b1; operation = 3'd5; primaryOperand = 16'h00C3; secondaryOperand = 16'h0101;
    @(posedge clock); #1;
    operation = 3'd0; primaryOperand = a2; secondaryOperand = b2;
    n_done = 0;
    for (int k = 1; k <= l1; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 1 || done !== 1'b1 || result !== r1 || flags !== f1) begin
      n_miss++;
      $display("FAIL b2b_first: dones=%0d done=%b result=%h flags=%b, required dones=1 done=1 result=%h flags=%b",
               n_done, done, result, flags, r1, f1);
    end
    @(posedge clock); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_miss++;
      $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    lat  = 0;
    seen = 0;
    while (!seen && lat < 64) begin
      @(posedge clock); #1;
      lat++;
      if (done === 1'b1) seen = 1;
    end
    n_vec++;
    if (!seen || lat != l2 || result !== r2 || flags !== f2) begin
      n_miss++;
      $display("FAIL b2b_second: seen=%b lat=%0d result=%h flags=%b, required lat=%0d result=%h flags=%b",
               seen, lat, result, flags, l2, r2, f2);
    end
    last_r = r2;
    last_f = f2;
    @(posedge clock); #1;
  endtask

  // Reset asserted mid-operation at cycle 5: immediate clear, no done afterwards.
  task automatic test_abort(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input string name);
    int n_done;
    start = 1'b1; operation = op; primaryOperand = a; secondaryOperand = b;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #4 reset = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || flags !== 4'b0) begin
      n_miss++;
      $display("FAIL %s: busy=%b done=%b result=%h flags=%b, required all 0", name, busy, done, result, flags);
    end
    #2 reset = 1'b1;
    n_done = 0;
    repeat (24) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) n_done++;
    end
    n_vec++;
    if (n_done != 0 || result !== '0 || flags !== 4'b0) begin
      n_miss++;
      $display("FAIL %s_after: done/busy cycles=%0d result=%h flags=%b, required 0 cycles result=0 flags=0",
               name, n_done, result, flags);
    end
    last_r = '0;
    last_f = 4'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    operation = '0;
    primaryOperand = '0;
    secondaryOperand = '0;
    #12;
    test_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    test_directed();
    test_back_to_back();
    test_random();
    test_abort(3'd5, 16'h1234, 16'h00FF, "abort_mul");
    run_model(3'd0, 16'h0001, 16'h0002, "after_abort");
    test_abort(3'd6, 16'h0F0F, 16'h000C, "abort_shl");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
